li_ram_arb: RTL

LI_RAM_ARB -- requirements
Module: li_ram_arb

---
 rtl/li_ram_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/li_ram_arb.sv
// Single-port-write RAM shared by NUM_RD round-robin read channels.
// Each channel has a 2-entry response FIFO so a stalled consumer never blocks the others.
module li_ram_arb #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr_in,
  input  logic [NUM_RD-1:0]            rd_req_valid_in,
  output logic [NUM_RD-1:0]            rd_req_ready_out,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_resp_data_out,
  output logic [NUM_RD-1:0]            rd_resp_valid_out,
  input  logic [NUM_RD-1:0]            rd_resp_ready_in,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_in,
  input  logic [DATA_WIDTH-1:0]        wr_data_in,
  input  logic                         wr_valid_in,
  output logic                         wr_ready_out
);

  localparam int unsigned PW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] fifo_q [NUM_RD][2];
  logic [1:0]            cnt_q [NUM_RD];
  logic [NUM_RD-1:0]     rd_ptr_q, wr_ptr_q, inflight_q;
  logic [NUM_RD-1:0]     resp_valid, pop, eligible, grant;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  wr_fire;

  assign wr_ready_out      = ~rst;
  assign wr_fire           = wr_valid_in & wr_ready_out;
  assign rd_req_ready_out  = grant;
  assign rd_resp_valid_out = resp_valid;

  // A response leaving this cycle frees its slot, so a single always-ready consumer
  // can still be granted every cycle.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      resp_valid[i] = (cnt_q[i] != 2'd0);
      rd_resp_data_out[i*DATA_WIDTH +: DATA_WIDTH] = fifo_q[i][rd_ptr_q[i]];
      pop[i]      = resp_valid[i] & rd_resp_ready_in[i];
      eligible[i] = ~rst & rd_req_valid_in[i] &
                    ((int'(cnt_q[i]) + int'(inflight_q[i]) - int'(pop[i])) < 2);
    end
  end

  // Round-robin: first pass covers channels at/after the pointer, second pass wraps.
  always_comb begin
    logic found;
    found      = 1'b0;
    grant      = '0;
    ptr_d      = ptr_q;
    grant_addr = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (!found && eligible[i] && ((p == 0) == (i >= int'(ptr_q)))) begin
          found      = 1'b1;
          grant[i]   = 1'b1;
          grant_addr = rd_req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
          ptr_d      = (i == int'(NUM_RD) - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  // RAM contents are deliberately not reset; a same-cycle write wins over the stored word.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr_in] <= wr_data_in;
    end
    if (|grant) begin
      rd_data_q <= (wr_fire && (wr_addr_in == grant_addr)) ? wr_data_in : mem[grant_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        cnt_q[i]     <= 2'd0;
        fifo_q[i][0] <= '0;
        fifo_q[i][1] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= grant;
      for (int i = 0; i < NUM_RD; i++) begin
        if (inflight_q[i]) begin
          fifo_q[i][wr_ptr_q[i]] <= rd_data_q;
          wr_ptr_q[i]            <= ~wr_ptr_q[i];
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= ~rd_ptr_q[i];
        end
        cnt_q[i] <= cnt_q[i] + {1'b0, inflight_q[i]} - {1'b0, pop[i]};
      end
    end
  end

endmodule
